// File: rtl/game_pkg.sv
// Shared types and helpers for the match referee: FSM state encoding and
// player-id conversion (id 0 means no player / draw, id i+1 is player i).
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    ROUND_OVER,
    MATCH_OVER
  } referee_state_e;

  localparam int PID_NONE = 0;

  function automatic int pid_of(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/lowest_index_picker.sv
// Combinational lowest-set-bit finder: presence, index, isolated one-hot bit,
// and whether exactly one bit is set.
module lowest_index_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     bits,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             count_is_one
);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) idx = IDX_W'(i);
    end
  end

  assign any          = |bits;
  assign onehot       = bits & (~bits + N'(1));
  assign count_is_one = any && ((bits & (bits - N'(1))) == '0);

endmodule

// File: rtl/match_referee.sv
// N-player referee: resolves each round from winner/loser flags, keeps
// per-player round tallies and declares a champion at WINS_TO_MATCH.
module match_referee
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS   = 4,
  parameter int SCORE_W       = 4,
  parameter int WINS_TO_MATCH = 3,
  parameter int CNT_W         = 8,
  parameter int PID_W         = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         winner_flag,
  input  logic [NUM_PLAYERS-1:0]         loser_flag,
  input  logic                           next_round,
  output logic [PID_W-1:0]               who,
  output logic                           gameover,
  output logic                           round_done,
  output logic                           match_over,
  output logic [PID_W-1:0]               champion,
  output logic [NUM_PLAYERS-1:0]         alive,
  output logic [NUM_PLAYERS*SCORE_W-1:0] tally,
  output logic [CNT_W-1:0]               round_count
);

  localparam int IDX_W = $clog2(NUM_PLAYERS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  referee_state_e           state_reg;
  logic [PID_W-1:0]         who_reg;
  logic                     gameover_reg;
  logic                     round_done_reg;
  logic                     match_over_reg;
  logic [PID_W-1:0]         champion_reg;
  logic [NUM_PLAYERS-1:0]   alive_reg;
  logic [SCORE_W-1:0]       tally_reg [NUM_PLAYERS];
  logic [CNT_W-1:0]         round_count_reg;

  logic [NUM_PLAYERS-1:0]   win_cand;
  logic [NUM_PLAYERS-1:0]   survivors;
  logic                     w_any, w_one, s_any, s_one;
  logic [IDX_W-1:0]         w_idx, s_idx;
  logic [NUM_PLAYERS-1:0]   w_oh, s_oh;
  logic                     win_valid, resolve;
  logic [IDX_W-1:0]         win_idx;
  logic [NUM_PLAYERS-1:0]   win_oh;
  logic [SCORE_W-1:0]       tally_next [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]   match_hit;
  logic                     unused_w_one;

  // Only players still in the round may win or be eliminated.
  assign win_cand  = winner_flag & alive_reg;
  assign survivors = alive_reg & ~loser_flag;

  lowest_index_picker #(.N(NUM_PLAYERS), .IDX_W(IDX_W)) u_win_pick (
    .bits(win_cand), .any(w_any), .idx(w_idx), .onehot(w_oh), .count_is_one(w_one)
  );

  lowest_index_picker #(.N(NUM_PLAYERS), .IDX_W(IDX_W)) u_surv_pick (
    .bits(survivors), .any(s_any), .idx(s_idx), .onehot(s_oh), .count_is_one(s_one)
  );

  assign unused_w_one = w_one;
  assign win_valid    = w_any | s_one;
  assign resolve      = win_valid | ~s_any;
  assign win_idx      = w_any ? w_idx : s_idx;
  assign win_oh       = w_any ? w_oh : s_oh;

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
      assign tally_next[gi] = (tally_reg[gi] == SCORE_MAX) ? tally_reg[gi]
                                                          : tally_reg[gi] + SCORE_W'(1);
      assign match_hit[gi]  = win_oh[gi] && (tally_next[gi] == SCORE_W'(WINS_TO_MATCH));
      assign tally[gi*SCORE_W +: SCORE_W] = tally_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    round_done_reg <= 1'b0;
    if (reset) begin
      state_reg       <= IDLE;
      who_reg         <= PID_W'(PID_NONE);
      gameover_reg    <= 1'b0;
      match_over_reg  <= 1'b0;
      champion_reg    <= PID_W'(PID_NONE);
      alive_reg       <= '0;
      round_count_reg <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) tally_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE, MATCH_OVER: begin
          if (start) begin
            state_reg       <= PLAY;
            who_reg         <= PID_W'(PID_NONE);
            gameover_reg    <= 1'b0;
            match_over_reg  <= 1'b0;
            champion_reg    <= PID_W'(PID_NONE);
            alive_reg       <= '1;
            round_count_reg <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) tally_reg[i] <= '0;
          end
        end
        PLAY: begin
          alive_reg <= survivors;
          if (resolve) begin
            who_reg         <= win_valid ? PID_W'(pid_of(int'(win_idx))) : PID_W'(PID_NONE);
            gameover_reg    <= 1'b1;
            round_done_reg  <= 1'b1;
            round_count_reg <= (round_count_reg == '1) ? round_count_reg
                                                       : round_count_reg + CNT_W'(1);
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (win_valid && win_oh[i]) tally_reg[i] <= tally_next[i];
            end
            if (win_valid && |match_hit) begin
              state_reg      <= MATCH_OVER;
              match_over_reg <= 1'b1;
              champion_reg   <= PID_W'(pid_of(int'(win_idx)));
            end else begin
              state_reg <= ROUND_OVER;
            end
          end
        end
        ROUND_OVER: begin
          if (next_round) begin
            state_reg    <= PLAY;
            alive_reg    <= '1;
            who_reg      <= PID_W'(PID_NONE);
            gameover_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign who         = who_reg;
  assign gameover    = gameover_reg;
  assign round_done  = round_done_reg;
  assign match_over  = match_over_reg;
  assign champion    = champion_reg;
  assign alive       = alive_reg;
  assign round_count = round_count_reg;

endmodule
